// File: rtl/bank_stream_io_if.sv
// bank_stream_io_if: stream, control and bank-port signals of the bank stream controller
interface bank_stream_io_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 14
);
  logic                  start_load;
  logic                  start_dump;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] bank_A1;
  logic [ADDR_WIDTH-1:0] bank_A2;
  logic [DATA_WIDTH-1:0] bank_D;
  logic                  bank_WEN;
  logic                  bank_REN;
  logic                  bank_EN;
  logic [DATA_WIDTH-1:0] bank_Q;
  modport slave (
    input  start_load, start_dump, in_valid, in_data, out_ready, bank_Q,
    output in_ready, out_valid, out_data, busy, done,
           bank_A1, bank_A2, bank_D, bank_WEN, bank_REN, bank_EN
  );
  modport master (
    output start_load, start_dump, in_valid, in_data, out_ready, bank_Q,
    input  in_ready, out_valid, out_data, busy, done,
           bank_A1, bank_A2, bank_D, bank_WEN, bank_REN, bank_EN
  );
endinterface

// File: rtl/bank_stream_io.sv
// bank_stream_io: loads a coefficient stream into a data bank and dumps it back as a stream
module bank_stream_io #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 14,
  parameter int DEPTH      = 256
) (
  input logic              clk,
  input logic              rst,
  bank_stream_io_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DUMP} state_t;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [ADDR_WIDTH:0]   rcnt_q, rcnt_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  rp_q, rp_d, wp_q, wp_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  acc, issue, pop, last;
  // next-state: LOAD writes, DUMP issues reads under FIFO credit and drains the 2-entry FIFO
  always_comb begin
    acc        = state_q == LOAD && bus.in_valid && !rst;
    pop        = cnt_q != 2'd0 && bus.out_ready;
    issue      = state_q == DUMP && !rst && rcnt_q < DEPTH_C &&
                 (3'(cnt_q) + 3'(inflight_q) < 3'd2 + 3'(pop));
    last       = pop && rcnt_q == DEPTH_C && !inflight_q && cnt_q == 2'd1;
    state_d    = state_q;
    done_d     = 1'b0;
    mem_d      = mem_q;
    wp_d       = wp_q;
    if (state_q == IDLE)
      state_d = bus.start_load ? LOAD : bus.start_dump ? DUMP : IDLE;
    wcnt_d     = acc ? (wcnt_q == LAST_A ? '0 : wcnt_q + 1'b1) : wcnt_q;
    rcnt_d     = issue ? rcnt_q + 1'b1 : rcnt_q;
    inflight_d = issue;
    if (inflight_q) begin
      mem_d[wp_q] = bus.bank_Q;
      wp_d        = ~wp_q;
    end
    rp_d       = pop ? ~rp_q : rp_q;
    cnt_d      = cnt_q + 2'(inflight_q) - 2'(pop);
    if ((acc && wcnt_q == LAST_A) || last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    if (last) rcnt_d = '0;
  end
  assign bus.in_ready  = state_q == LOAD;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.out_valid = cnt_q != 2'd0;
  assign bus.out_data  = mem_q[rp_q];
  assign bus.bank_WEN  = acc;
  assign bus.bank_A1   = acc ? wcnt_q : '0;
  assign bus.bank_D    = acc ? bus.in_data : '0;
  assign bus.bank_REN  = issue;
  assign bus.bank_A2   = issue ? rcnt_q[ADDR_WIDTH-1:0] : '0;
  assign bus.bank_EN   = acc | issue;
  // state, counters and FIFO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rp_q       <= 1'b0;
      wp_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      mem_q      <= mem_d;
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bank_stream_io.sv
// tb_bank_stream_io: directed checks of load, dump, backpressure, start priority and mid-pass reset
module tb_bank_stream_io;
  localparam int AW = 8, DW = 14, DEPTH = 256;
  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] bank [DEPTH];
  logic [DW-1:0] q_model;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  bank_stream_io_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  bank_stream_io #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  assign bus.bank_Q = q_model;
  always @(posedge clk) begin
    if (bus.bank_WEN) bank[bus.bank_A1] <= bus.bank_D;
    if (bus.bank_REN) q_model <= bank[bus.bank_A2];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  initial begin
    int e, k, w, c;
    logic ready, hold_v;
    logic [DW-1:0] held;
    logic [3:0] pat;
    q_model = '0;
    bus.start_load = 0; bus.start_dump = 0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_en", bus.bank_EN, 0);
    chk("rst_a1", bus.bank_A1, 0);
    chk("rst_a2", bus.bank_A2, 0);
    chk("rst_d", bus.bank_D, 0);
    bus.start_load = 1; bus.in_valid = 1; bus.in_data = DW'(100);
    @(negedge clk);
    bus.start_load = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_data = DW'(100 + i);
      #1;
      chk("ld_wen", bus.bank_WEN, 1);
      chk("ld_a1", bus.bank_A1, i);
      chk("ld_d", bus.bank_D, 100 + i);
      chk("ld_done_low", bus.done, 0);
      @(negedge clk);
    end
    chk("ld_in_ready_end", bus.in_ready, 0);
    chk("ld_done", bus.done, 1);
    chk("ld_busy_end", bus.busy, 0);
    chk("ld_no_extra_wen", bus.bank_WEN, 0);
    bus.in_valid = 0;
    @(negedge clk);
    chk("ld_done_once", bus.done, 0);
    bus.out_ready = 1; bus.start_dump = 1;
    @(negedge clk);
    bus.start_dump = 0;
    chk("dm_v0", bus.out_valid, 0);
    chk("dm_busy", bus.busy, 1);
    @(negedge clk);
    chk("dm_v1", bus.out_valid, 0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("dm_valid", bus.out_valid, 1);
      chk("dm_data", bus.out_data, 100 + i);
    end
    @(negedge clk);
    chk("dm_done", bus.done, 1);
    chk("dm_busy_end", bus.busy, 0);
    chk("dm_valid_end", bus.out_valid, 0);
    bus.out_ready = 0; bus.start_dump = 1;
    @(negedge clk);
    bus.start_dump = 0;
    e = 0; k = 0; hold_v = 0; held = '0; pat = 4'b1001;
    while (e < DEPTH && k < 4000) begin
      ready = pat[k[1:0]] && ($urandom_range(0, 9) >= 3);
      bus.out_ready = ready;
      if (hold_v) begin
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_data", bus.out_data, held);
      end
      if (bus.out_valid && ready) begin
        chk("bp_data", bus.out_data, 100 + e);
        e++;
      end
      hold_v = bus.out_valid && !ready;
      held = bus.out_data;
      k++;
      @(negedge clk);
    end
    chk("bp_count", e, DEPTH);
    chk("bp_done", bus.done, 1);
    bus.out_ready = 0; bus.start_load = 1; bus.start_dump = 1;
    @(negedge clk);
    bus.start_load = 0; bus.start_dump = 0;
    chk("both_in_ready", bus.in_ready, 1);
    w = 0; c = 0;
    while (w < DEPTH && c < 2000) begin
      bus.in_valid = (c % 3 == 2);
      bus.in_data = DW'(100 + w);
      bus.start_dump = (c == 10);
      #1;
      chk("gap_wen", bus.bank_WEN, bus.in_valid);
      chk("gap_ren", bus.bank_REN, 0);
      if (bus.in_valid) begin
        chk("gap_a1", bus.bank_A1, w);
        w++;
      end
      c++;
      @(negedge clk);
    end
    bus.in_valid = 0; bus.start_dump = 0;
    chk("gap_count", w, DEPTH);
    chk("gap_done", bus.done, 1);
    chk("gap_busy_end", bus.busy, 0);
    bus.out_ready = 1; bus.start_dump = 1;
    @(negedge clk);
    bus.start_dump = 0;
    @(negedge clk);
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      chk("rs_data", bus.out_data, 100 + i);
    end
    rst = 1;
    #1;
    chk("rs_no_bank_access", bus.bank_EN, 0);
    @(negedge clk);
    rst = 0;
    chk("rs_out_valid", bus.out_valid, 0);
    chk("rs_busy", bus.busy, 0);
    chk("rs_done", bus.done, 0);
    @(negedge clk);
    chk("rs_done_after", bus.done, 0);
    bus.start_dump = 1;
    @(negedge clk);
    bus.start_dump = 0;
    chk("rs2_v0", bus.out_valid, 0);
    @(negedge clk);
    chk("rs2_v1", bus.out_valid, 0);
    @(negedge clk);
    chk("rs2_valid", bus.out_valid, 1);
    chk("rs2_first", bus.out_data, 100);
    @(negedge clk);
    chk("rs2_second", bus.out_data, 101);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bank_stream_io.md
Name: bank_stream_io

Overview:
- Initiator-side controller for one coefficient data bank: one synchronous write port, one synchronous read port, 1-cycle registered read, read output holds when not enabled.
- LOAD phase: takes a valid/ready coefficient stream and writes it into bank addresses 0..DEPTH-1.
- DUMP phase: reads addresses 0..DEPTH-1 back out as a valid/ready stream. Hides the bank read latency and tolerates arbitrary downstream backpressure.
- Sits between the polynomial I/O interface and the NTT bank array.

Parameters:
- ADDR_WIDTH, 8, bank address width.
- DATA_WIDTH, 14, coefficient width.
- DEPTH, 256, words per pass; must be ≤ 2^ADDR_WIDTH and ≥ 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start_load  input  1  1-cycle request to begin LOAD; sampled only in IDLE.
- start_dump  input  1  1-cycle request to begin DUMP; sampled only in IDLE.
- in_valid  input  1  input word valid.
- in_data  input  DATA_WIDTH  input coefficient.
- in_ready  output  1  controller accepts in_data.
- out_valid  output  1  output word valid.
- out_data  output  DATA_WIDTH  output coefficient.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  1-cycle pulse at the end of a pass.
- bank_A1  output  ADDR_WIDTH  bank write address.
- bank_A2  output  ADDR_WIDTH  bank read address.
- bank_D  output  DATA_WIDTH  bank write data.
- bank_WEN  output  1  bank write enable.
- bank_REN  output  1  bank read enable.
- bank_EN  output  1  bank enable; equals bank_WEN | bank_REN.
- bank_Q  input  DATA_WIDTH  bank read data; valid the cycle after bank_REN, held otherwise.

Behaviour:
- Reset: state IDLE; counters 0; output FIFO empty; in-flight flag 0. in_ready, out_valid, busy, done, bank_WEN, bank_REN, bank_EN all 0. bank_A1, bank_A2, bank_D = 0.
- Reset mid-pass: abandons the pass, no done pulse, discards FIFO contents. No bank write occurs in the reset cycle.
- States: IDLE, LOAD, DUMP.
- IDLE transitions:
  - start_load → LOAD.
  - else start_dump → DUMP.
  - Both high together → LOAD wins; start_dump is dropped.
  - Starts outside IDLE are ignored.
- LOAD:
  - in_ready = 1 (combinational, state only).
  - On in_valid & in_ready: bank_WEN = 1, bank_A1 = wcnt, bank_D = in_data, all combinational in the same cycle. Then wcnt increments.
  - in_valid low → no write, wcnt holds.
  - On the accept with wcnt == DEPTH-1: wcnt → 0, state → IDLE, done = 1 next cycle. No address wrap-around beyond DEPTH-1.
- DUMP read issue:
  - 2-entry output FIFO; credit rule: FIFO occupancy + in-flight reads − (pop this cycle) < 2.
  - Read issued when rcnt < DEPTH and the credit rule holds. Issue sets bank_REN = 1, bank_A2 = rcnt; rcnt increments and the in-flight flag sets.
  - Next cycle: bank_Q is pushed into the FIFO.
  - Issue, push and pop may all occur in the same cycle.
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Pop on out_valid & out_ready.
- DUMP throughput and latency:
  - Sustained 1 word/cycle when out_ready is held high.
  - First out_valid appears 2 cycles after entering DUMP: read issued in the first DUMP cycle, data pushed on the next edge.
  - Backpressure never loses or duplicates a word; out_data is stable while out_valid & !out_ready.
- DUMP exit: when the word read from address DEPTH-1 is popped → state IDLE, rcnt → 0, done pulses next cycle.
- bank_A1/bank_A2 are don't-care when their enable is low; drive 0.
- No simultaneous write and read: LOAD and DUMP are exclusive.

Test Plan:
- Reset, then start_load with DEPTH=256 and in_valid held high, data = 100+i → 256 writes to addresses 0..255, one per cycle. in_ready drops after the 256th. done pulses once, 1 cycle after the last write; busy falls with it.
- start_dump after the load, out_ready = 1 → out_valid first high 2 cycles after start. 256 consecutive words 100..355, no bubbles, done after the last pop.
- DUMP with out_ready toggling 1,0,0,1,… and random 30% stalls → exact sequence 100..355 with no duplicates or drops. out_data stable during stalls. FIFO never exceeds 2 entries.
- LOAD with in_valid gaps (valid every 3rd cycle) → writes occur only on valid cycles; addresses stay contiguous 0..255.
- start_load and start_dump asserted in the same cycle → LOAD entered. A start_dump pulse mid-LOAD is ignored and no reads are issued.
- rst asserted at word 40 of DUMP → next cycle out_valid = 0, busy = 0, no done. A following start_dump restarts from address 0 with first word 100.
